// File: rtl/lcd_tx_ctrl_if.sv
// lcd_tx_ctrl_if: request handshake plus LCD pin bundle for the transmit controller
interface lcd_tx_ctrl_if;
    logic        req_vld;
    logic        req_rs;
    logic [7:0]  req_data;
    logic        req_rdy;
    logic        busy;
    logic        init_done;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        lcd_on;
    logic [31:0] io_lcd;
    modport master (
        output req_vld, req_rs, req_data,
        input  req_rdy, busy, init_done, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, io_lcd
    );
    modport slave (
        input  req_vld, req_rs, req_data,
        output req_rdy, busy, init_done, lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, io_lcd
    );
endinterface

// File: rtl/lcd_tx_ctrl.sv
// lcd_tx_ctrl: delay-timed HD44780 8-bit write controller with automatic power-up init
module lcd_tx_ctrl #(
    parameter int PWR_UP_CYC     = 750000,
    parameter int SETUP_CYC      = 2,
    parameter int EN_HIGH_CYC    = 12,
    parameter int HOLD_CYC       = 2,
    parameter int SHORT_WAIT_CYC = 1850,
    parameter int LONG_WAIT_CYC  = 76000
) (
    input logic i_clk,
    input logic i_rst,
    lcd_tx_ctrl_if.slave bus
);
    typedef enum logic [2:0] {PWRUP, SETUP, EN_HI, HOLD, WAIT, IDLE} state_t;
    localparam int M0 = PWR_UP_CYC > LONG_WAIT_CYC ? PWR_UP_CYC : LONG_WAIT_CYC;
    localparam int M1 = M0 > SHORT_WAIT_CYC ? M0 : SHORT_WAIT_CYC;
    localparam int M2 = M1 > EN_HIGH_CYC ? M1 : EN_HIGH_CYC;
    localparam int M3 = M2 > SETUP_CYC ? M2 : SETUP_CYC;
    localparam int MAX_CYC = M3 > HOLD_CYC ? M3 : HOLD_CYC;
    localparam int CW = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] PWR_LAST   = CW'(PWR_UP_CYC);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LAST    = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] SHORT_LAST = CW'(SHORT_WAIT_CYC - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_WAIT_CYC - 1);

    function automatic logic [7:0] rom(input logic [1:0] i);
        return i == 2'd0 ? 8'h38 : i == 2'd1 ? 8'h0C : i == 2'd2 ? 8'h01 : 8'h06;
    endfunction

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n, wait_last;
    logic [1:0] idx, idx_n;
    logic [7:0] data, data_n;
    logic rs, rs_n, en, en_n, rdy, rdy_n, done, done_n, on, on_n;

    // clear (0x01) and home (0x02/0x03) commands need the long execution wait
    assign wait_last = (!rs && data[7:2] == 6'd0 && data[1:0] != 2'd0) ? LONG_LAST : SHORT_LAST;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= PWRUP;
            cnt   <= '0;
            idx   <= '0;
            data  <= '0;
            rs    <= 1'b0;
            en    <= 1'b0;
            rdy   <= 1'b0;
            done  <= 1'b0;
            on    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            data  <= data_n;
            rs    <= rs_n;
            en    <= en_n;
            rdy   <= rdy_n;
            done  <= done_n;
            on    <= on_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        data_n  = data;
        rs_n    = rs;
        done_n  = done;
        on_n    = 1'b1;
        case (state)
            PWRUP: if (cnt == PWR_LAST) begin
                state_n = SETUP;
                cnt_n   = '0;
                idx_n   = 2'd0;
                data_n  = rom(2'd0);
                rs_n    = 1'b0;
            end
            SETUP: if (cnt == SETUP_LAST) begin
                state_n = EN_HI;
                cnt_n   = '0;
            end
            EN_HI: if (cnt == EN_LAST) begin
                state_n = HOLD;
                cnt_n   = '0;
            end
            HOLD: if (cnt == HOLD_LAST) begin
                state_n = WAIT;
                cnt_n   = '0;
            end
            WAIT: if (cnt == wait_last) begin
                cnt_n = '0;
                if (idx == 2'd3) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    state_n = SETUP;
                    idx_n   = idx + 2'd1;
                    data_n  = rom(idx + 2'd1);
                    rs_n    = 1'b0;
                end
            end
            IDLE: begin
                cnt_n = '0;
                if (bus.req_vld) begin
                    state_n = SETUP;
                    data_n  = bus.req_data;
                    rs_n    = bus.req_rs;
                end
            end
            default: state_n = PWRUP;
        endcase
        en_n  = state_n == EN_HI;
        rdy_n = state_n == IDLE;
    end

    assign bus.req_rdy   = rdy;
    assign bus.busy      = ~rdy;
    assign bus.init_done = done;
    assign bus.lcd_data  = data;
    assign bus.lcd_rs    = rs;
    assign bus.lcd_rw    = 1'b0;
    assign bus.lcd_en    = en;
    assign bus.lcd_on    = on;
    assign bus.io_lcd    = {on, 20'b0, en, rs, 1'b0, data};
endmodule

// File: tb/tb_lcd_tx_ctrl.sv
// tb_lcd_tx_ctrl: timeline model of the LCD write controller checked every cycle,
// plus hand-computed cycle numbers for init and single-op timing.
module tb_lcd_tx_ctrl;
    localparam int PWR = 20, S = 2, E = 4, H = 2, SW = 10, LW = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lcd_tx_ctrl_if bus();
    lcd_tx_ctrl #(
        .PWR_UP_CYC(PWR), .SETUP_CYC(S), .EN_HIGH_CYC(E),
        .HOLD_CYC(H), .SHORT_WAIT_CYC(SW), .LONG_WAIT_CYC(LW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    int n_chk = 0, n_pass = 0;

    int cyc = -1, op_a = 0, op_len = 0, init_k = 0, n_acc = 0, t = 0;
    bit op_act = 0, m_done = 0, m_idle = 0, e_on = 0, e_en = 0;
    logic e_rs = 1'b0;
    logic [7:0] e_data = 8'h00;
    logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    int rises[$];
    int falls[$];
    logic [7:0] rise_data[$];
    int init_rdy = -1, last_rdy = -1, n_rise = 0;
    logic [31:0] io_at_en = 32'h0;
    bit prev_en = 0, prev_rdy = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic start_op(input logic rs, input logic [7:0] d);
        op_act = 1;
        op_a   = cyc;
        e_rs   = rs;
        e_data = d;
        op_len = S + E + H + ((!rs && d >= 8'd1 && d <= 8'd3) ? LW : SW);
    endtask

    // model: each op is a fixed timeline starting at its load edge
    initial forever begin
        @(posedge clk);
        if (rst) begin
            cyc = -1; op_act = 0; init_k = 0; m_done = 0; m_idle = 0;
            e_on = 0; e_rs = 1'b0; e_data = 8'h00;
        end else begin
            cyc++;
            e_on = 1;
            if (cyc == PWR) begin
                start_op(1'b0, rom[0]);
                init_k = 1;
            end else if (op_act && cyc == op_a + op_len) begin
                op_act = 0;
                if (init_k < 4) begin
                    start_op(1'b0, rom[init_k]);
                    init_k++;
                end else begin
                    m_done = 1;
                    m_idle = 1;
                end
            end else if (m_idle && bus.req_vld) begin
                m_idle = 0;
                n_acc++;
                start_op(bus.req_rs, bus.req_data);
            end
        end
        @(negedge clk);
        t = cyc - op_a;
        e_en = op_act && t >= S && t < S + E;
        check("io_lcd", bus.io_lcd, {e_on, 20'b0, e_en, e_rs, 1'b0, e_data});
        check("pins", {20'b0, bus.lcd_on, bus.lcd_en, bus.lcd_rs, bus.lcd_rw, bus.lcd_data},
              {20'b0, e_on, e_en, e_rs, 1'b0, e_data});
        check("req_rdy", 32'(bus.req_rdy), 32'(m_idle));
        check("busy", 32'(bus.busy), 32'(!m_idle));
        check("init_done", 32'(bus.init_done), 32'(m_done));
        if (cyc < 0) begin
            rises.delete(); falls.delete(); rise_data.delete(); init_rdy = -1;
        end else begin
            if (bus.lcd_en && !prev_en) begin
                rises.push_back(cyc);
                rise_data.push_back(bus.lcd_data);
                io_at_en = bus.io_lcd;
                n_rise++;
            end
            if (!bus.lcd_en && prev_en) falls.push_back(cyc);
            if (bus.req_rdy && !prev_rdy) begin
                last_rdy = cyc;
                if (init_rdy < 0) init_rdy = cyc;
            end
        end
        prev_en  = bus.lcd_en;
        prev_rdy = bus.req_rdy;
    end

    task automatic check_init(input int n);
        int er[4] = '{22, 40, 58, 96};
        int ef[4] = '{26, 44, 62, 100};
        logic [7:0] ed[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
        check("en_pulses", rises.size(), n);
        for (int i = 0; i < 4; i++) begin
            check("en_rise", i < rises.size() ? 32'(rises[i]) : 32'hFFFFFFFF, er[i]);
            check("en_fall", i < falls.size() ? 32'(falls[i]) : 32'hFFFFFFFF, ef[i]);
            check("init_data", i < rise_data.size() ? 32'(rise_data[i]) : 32'hFFFFFFFF, 32'(ed[i]));
        end
        check("init_rdy_cycle", init_rdy, 112);
    endtask

    task automatic send(input logic rs, input logic [7:0] d, output int a);
        bus.req_vld = 1'b1; bus.req_rs = rs; bus.req_data = d;
        a = -1;
        for (int i = 0; i < 200 && a < 0; i++) begin
            if (bus.req_rdy) begin
                @(negedge clk);
                a = cyc;
            end else @(negedge clk);
        end
        bus.req_vld = 1'b0;
        if (a < 0) check("accept_timeout", 32'h0, 32'h1);
    endtask

    logic       c_rs[7]  = '{0, 0, 0, 0, 0, 0, 1};
    logic [7:0] c_dat[7] = '{8'h01, 8'h02, 8'h03, 8'h80, 8'h00, 8'h04, 8'h01};
    int         c_len[7] = '{38, 38, 38, 18, 18, 18, 18};

    initial begin
        int a, r0, a0;
        bus.req_vld = 1'b0; bus.req_rs = 1'b0; bus.req_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_io", bus.io_lcd, 32'h0);
        rst = 1'b0;
        repeat (121) @(negedge clk);
        check_init(4);

        send(1'b1, 8'h41, a);
        repeat (21) @(negedge clk);
        check("op_en_rise", rises.size() > 0 ? 32'(rises[rises.size()-1]) : 32'hFFFFFFFF, a + 2);
        check("op_en_fall", falls.size() > 0 ? 32'(falls[falls.size()-1]) : 32'hFFFFFFFF, a + 6);
        check("op_rdy_back", last_rdy, a + 18);
        check("op_io_en", io_at_en, 32'h80000641);

        for (int i = 0; i < 7; i++) begin
            send(c_rs[i], c_dat[i], a);
            repeat (c_len[i] + 3) @(negedge clk);
            check("cmd_rdy_back", last_rdy, a + c_len[i]);
        end

        r0 = n_rise; a0 = n_acc;
        bus.req_vld = 1'b1;
        for (int i = 0; i < 80; i++) begin
            bus.req_data = 8'(i * 7 + 3);
            bus.req_rs = i[0];
            @(negedge clk);
        end
        bus.req_vld = 1'b0;
        repeat (45) @(negedge clk);
        check("pulses_per_accept", n_rise - r0, n_acc - a0);

        send(1'b1, 8'h5A, a);
        repeat (3) @(negedge clk);
        check("en_mid_write", 32'(bus.lcd_en), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_io", bus.io_lcd, 32'h0);
        check("abort_done", 32'(bus.init_done), 32'h0);
        rst = 1'b0;
        repeat (121) @(negedge clk);
        check_init(4);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req_vld = 1'b1; bus.req_rs = 1'b1; bus.req_data = 8'h55;
        repeat (116) @(negedge clk);
        bus.req_vld = 1'b0;
        repeat (10) @(negedge clk);
        check_init(5);
        check("late_accept_rise", rises.size() > 4 ? 32'(rises[4]) : 32'hFFFFFFFF, 115);
        check("late_accept_data", rise_data.size() > 4 ? 32'(rise_data[4]) : 32'hFFFFFFFF, 32'h55);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
